// File: rtl/present_decrypt_core.sv
// present_decrypt_core
//   Iterative PRESENT-80 decryption. The core expands the user key forward
//   to the last round key, whitens the ciphertext, and then removes one
//   round per clock. While doing so it walks the key schedule backwards.
// Ports
//   sys_clk    : clock, all state changes on the rising edge
//   sys_rst    : synchronous active-low reset
//   in_valid   : ciphertext/key offered
//   in_ready   : core idle and able to take a job (registered)
//   in_cipher  : 64-bit ciphertext, sampled only at the input handshake
//   in_key     : 80-bit user key, sampled only at the input handshake
//   out_valid  : out_plain holds a result (registered)
//   out_ready  : consumer takes the result
//   out_plain  : 64-bit recovered plaintext (registered)
//   busy       : key expansion or decryption in progress (registered)
module present_decrypt_core #(
  parameter int ROUNDS = 31
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_cipher,
  input  logic [79:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_plain,
  output logic        busy
);

  localparam logic [4:0] LAST_RC = 5'(ROUNDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    KEYEXP  = 2'd1,
    DECRYPT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [63:0] st_r, st_nxt_s;
  logic [79:0] k_r, k_nxt_s;
  logic [4:0]  rc_r, rc_nxt_s;
  logic [63:0] out_plain_r, plain_nxt_s;
  logic        out_valid_r, valid_nxt_s;
  logic        in_ready_r, ready_nxt_s;
  logic        busy_r, busy_nxt_s;
  logic        handshake_s;
  logic [79:0] k_fwd_s, k_inv_s;
  logic [63:0] st_dec_s;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  4'hF: y = 4'h2;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  4'hF: y = 4'hA;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] sinv_layer(input logic [63:0] x);
    logic [63:0] y;
    y = 64'd0;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = sbox_inv(x[4*n +: 4]);
    return y;
  endfunction

  // Forward permutation sends bit i to 16*i mod 63, so the inverse gathers from there.
  function automatic logic [63:0] pinv(input logic [63:0] x);
    logic [63:0] y;
    y = 64'd0;
    for (int i = 0; i < 63; i++) y[i] = x[(16 * i) % 63];
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [79:0] fwd_key(input logic [79:0] k, input logic [4:0] i);
    logic [79:0] r;
    r = {k[18:0], k[79:19]};
    r[79:76] = sbox(r[79:76]);
    r[19:15] = r[19:15] ^ i;
    return r;
  endfunction

  function automatic logic [79:0] inv_key(input logic [79:0] k, input logic [4:0] i);
    logic [79:0] r;
    r = k;
    r[19:15] = r[19:15] ^ i;
    r[79:76] = sbox_inv(r[79:76]);
    return {r[60:0], r[79:61]};
  endfunction

  assign handshake_s = in_valid & in_ready_r;
  assign k_fwd_s     = fwd_key(k_r, rc_r);
  assign k_inv_s     = inv_key(k_r, rc_r);
  assign st_dec_s    = sinv_layer(pinv(st_r)) ^ k_inv_s[79:16];

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_plain = out_plain_r;
  assign busy      = busy_r;

  // FSM state register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (handshake_s) state_nxt_s = KEYEXP;
        else             state_nxt_s = IDLE;
      end
      KEYEXP: begin
        if (rc_r == LAST_RC) state_nxt_s = DECRYPT;
        else                 state_nxt_s = KEYEXP;
      end
      DECRYPT: begin
        if (rc_r == 5'd1) state_nxt_s = DONE;
        else              state_nxt_s = DECRYPT;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    st_nxt_s    = st_r;
    k_nxt_s     = k_r;
    rc_nxt_s    = rc_r;
    plain_nxt_s = out_plain_r;
    valid_nxt_s = out_valid_r;
    case (state_r)
      IDLE: begin
        if (handshake_s) begin
          st_nxt_s = in_cipher;
          k_nxt_s  = in_key;
          rc_nxt_s = 5'd1;
        end else begin
          rc_nxt_s = rc_r;
        end
      end
      KEYEXP: begin
        k_nxt_s = k_fwd_s;
        if (rc_r == LAST_RC) begin
          // Whitening with the final round key, produced in this same cycle.
          st_nxt_s = st_r ^ k_fwd_s[79:16];
          rc_nxt_s = LAST_RC;
        end else begin
          rc_nxt_s = rc_r + 5'd1;
        end
      end
      DECRYPT: begin
        st_nxt_s = st_dec_s;
        k_nxt_s  = k_inv_s;
        rc_nxt_s = rc_r - 5'd1;
        if (rc_r == 5'd1) begin
          plain_nxt_s = st_dec_s;
          valid_nxt_s = 1'b1;
        end else begin
          valid_nxt_s = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) valid_nxt_s = 1'b0;
        else           valid_nxt_s = 1'b1;
      end
      default: begin
        valid_nxt_s = 1'b0;
      end
    endcase
    ready_nxt_s = (state_nxt_s == IDLE);
    busy_nxt_s  = (state_nxt_s == KEYEXP) || (state_nxt_s == DECRYPT);
  end

  // Datapath and output registers
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      st_r        <= 64'd0;
      k_r         <= 80'd0;
      rc_r        <= 5'd0;
      out_plain_r <= 64'd0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      st_r        <= st_nxt_s;
      k_r         <= k_nxt_s;
      rc_r        <= rc_nxt_s;
      out_plain_r <= plain_nxt_s;
      out_valid_r <= valid_nxt_s;
      in_ready_r  <= ready_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

endmodule
